// File: rtl/rng_arbiter_if.sv
// Bus between rng_arbiter and its users: requester handshake, the
// generated byte pair, and the control/data lines to the rng8 source.
interface rng_arbiter_if #(
    parameter int N_REQ = 4
);
    logic              reseed;
    logic [31:0]       new_seed;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [15:0]       rnd_data;
    logic              rnd_valid;
    logic              ready;
    logic [31:0]       rng_seed;
    logic              rng_rst;
    logic [7:0]        rnd1;
    logic [7:0]        rnd2;

    // Arbiter side
    modport slave (
        input  reseed, new_seed, req, rnd1, rnd2,
        output gnt, rnd_data, rnd_valid, ready, rng_seed, rng_rst
    );

    // Requesters / environment side
    modport master (
        output reseed, new_seed, req, rnd1, rnd2,
        input  gnt, rnd_data, rnd_valid, ready, rng_seed, rng_rst
    );
endinterface

// File: rtl/rng_arbiter.sv
// Sequencer and round-robin arbiter for the shared rng8 source.
// Loads a seed, holds rng8 in reset, discards a warm-up run, then hands
// out one fresh {rnd1, rnd2} pair per cycle to one requester.
module rng_arbiter #(
    parameter int          N_REQ         = 4,
    parameter int          SEED_CYCLES   = 2,
    parameter int          WARMUP_CYCLES = 32,
    parameter logic [31:0] DEFAULT_SEED  = 32'hACE1_2468
) (
    input  logic            clk,
    input  logic            reset,   // synchronous, active-low
    rng_arbiter_if.slave    bus
);
    localparam int CNT_MAX = (SEED_CYCLES > WARMUP_CYCLES) ? SEED_CYCLES : WARMUP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     ptr_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [15:0]       rnd_data_q;
    logic              rnd_valid_q;
    logic              ready_q;
    logic [31:0]       rng_seed_q;
    logic              rng_rst_q;

    logic              grant_found_d;
    logic [PW-1:0]     grant_idx_d;
    int                idx;

    // Round-robin search: first requesting index above the pointer, wrapping
    always_comb begin
        grant_found_d = 1'b0;
        grant_idx_d   = '0;
        idx           = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(ptr_q) + off) % N_REQ;
            if (!grant_found_d && bus.req[idx]) begin
                grant_found_d = 1'b1;
                grant_idx_d   = PW'(idx);
            end
        end
    end

    // Sequencer FSM with registered outputs; reseed overrides everything
    // except reset, and always restarts the full seed + warm-up sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_SEED;
            cnt_q       <= '0;
            ptr_q       <= PW'(N_REQ - 1);
            gnt_q       <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            rng_seed_q  <= DEFAULT_SEED;
            rng_rst_q   <= 1'b1;
        end else if (bus.reseed) begin
            state_q     <= ST_SEED;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            rng_seed_q  <= bus.new_seed;
            rng_rst_q   <= 1'b1;
        end else begin
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            case (state_q)
                ST_SEED: begin
                    if (cnt_q == CW'(SEED_CYCLES - 1)) begin
                        state_q   <= ST_WARMUP;
                        cnt_q     <= '0;
                        rng_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (cnt_q == CW'(WARMUP_CYCLES - 1)) begin
                        state_q <= ST_READY;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (grant_found_d) begin
                        gnt_q       <= N_REQ'(1) << grant_idx_d;
                        rnd_data_q  <= {bus.rnd1, bus.rnd2};
                        rnd_valid_q <= 1'b1;
                        ptr_q       <= grant_idx_d;
                    end
                end
                default: begin
                    state_q   <= ST_SEED;
                    cnt_q     <= '0;
                    rng_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_data  = rnd_data_q;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.ready     = ready_q;
    assign bus.rng_seed  = rng_seed_q;
    assign bus.rng_rst   = rng_rst_q;

endmodule
